alu_uart_sequencer: RTL and testbench
=====================================

Name: alu_uart_sequencer

Overview:
Initiator-side front end for the `alu` block: collects operand A, operand B and the opcode as three successive bytes from a byte receiver. It drives them into the ALU's combinational inputs and captures the ALU result. It then hands the result to a byte transmitter with a start/done handshake. Sits between the UART RX/TX pair and the `alu` in the top level.

Parameters:
N_BITS, 8, width of operands, result and serial bytes
N_OP, 6, width of opcode field (low N_OP bits of the opcode byte)

Ports:
i_clk  input  1  system clock, all state on rising edge
i_reset  input  1  asynchronous, active-high reset
i_rx_data  input  N_BITS  received byte, valid while i_rx_done=1
i_rx_done  input  1  one-cycle strobe: new byte on i_rx_data
i_alu_result  input  N_BITS  combinational result from alu o_alu
i_tx_done  input  1  one-cycle strobe: transmitter finished byte
o_dato_A  output  N_BITS  to alu i_dato_A (registered)
o_dato_B  output  N_BITS  to alu i_dato_B (registered)
o_operacion  output  N_OP  to alu i_operacion (registered)
o_tx_data  output  N_BITS  byte to transmit (registered)
o_tx_start  output  1  one-cycle pulse requesting transmission
o_busy  output  1  high in EXEC and WAIT_TX
o_error  output  1  sticky invalid-opcode flag (see Optional Feature)

Behaviour:
- Clock/reset: single clock i_clk; reset i_reset is asynchronous, active-high.
- Reset (any state, mid-sequence included): state=WAIT_A. o_dato_A, o_dato_B, o_operacion, o_tx_data = 0. o_tx_start, o_busy, o_error = 0. Partially collected operands are discarded.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX.
- WAIT_A: i_rx_done=1 -> o_dato_A<=i_rx_data, go WAIT_B.
- WAIT_B: i_rx_done=1 -> o_dato_B<=i_rx_data, go WAIT_OP.
- WAIT_OP: i_rx_done=1 -> o_operacion<=i_rx_data[N_OP-1:0], go EXEC. Upper byte bits are ignored.
- EXEC: exactly one cycle so the ALU settles on the registered inputs. At its end: o_tx_data<=i_alu_result, o_tx_start<=1 for one cycle, go WAIT_TX.
- WAIT_TX: o_tx_start=0. i_tx_done=1 -> go WAIT_A.
- Latency: the op byte strobe in cycle N gives o_tx_start=1 in cycle N+2, with o_tx_data valid the same cycle.
- o_dato_A/B/o_operacion hold their last values until overwritten. They are not cleared between transactions.
- i_rx_done in EXEC or WAIT_TX: byte dropped, no state change. This includes rx_done coincident with tx_done in WAIT_TX.
- i_tx_done outside WAIT_TX: ignored.
- o_tx_data holds until the next EXEC.
- o_busy = (state==EXEC)||(state==WAIT_TX), registered-state decode.
- No timeout; WAIT_TX waits indefinitely for i_tx_done.

Optional Feature:
Macro OP_CHECK_EN.
- Defined: in WAIT_OP, the opcode is checked against {0x20,0x22,0x24,0x25,0x26,0x03,0x02,0x27}.
  - Invalid opcode -> o_operacion unchanged, o_error<=1, state returns to WAIT_A, no transmission.
  - o_error clears on the next valid opcode or on reset.
- Undefined: no check. Every opcode goes through EXEC. o_error is tied to 0.

Test Plan:
- ADD: bytes 0x05,0x03,0x20 -> o_dato_A=0x05, o_dato_B=0x03, o_operacion=0x20; o_tx_start pulses 2 cycles after the op strobe with o_tx_data=0x08. i_tx_done -> state WAIT_A, o_busy=0.
- SUB wrap: 0x03,0x05,0x22 -> o_tx_data=0xFE. SRA: 0x80,0x02,0x03 -> 0xE0. NOR: 0x0F,0xF0,0x27 -> 0x00.
- Busy drop: after op byte, send 0x11 during WAIT_TX -> ignored. Next transaction 0x01,0x01,0x24 gives o_tx_data=0x01, and o_dato_A=0x01 (not 0x11).
- Reset mid-sequence: send 0x7F (A), assert i_reset asynchronously between clock edges. All outputs 0 immediately. Then 0x02,0x04,0x25 -> o_tx_data=0x06.
- Op byte 0xE0 (upper bits set) -> o_operacion=0x20 (ADD executed).
- OP_CHECK_EN defined: 0x05,0x03,0x3F -> o_error=1, no o_tx_start, state WAIT_A. Then 0x01,0x02,0x20 -> o_error=0, o_tx_data=0x03. Undefined: same 0x3F -> o_tx_start pulses, o_error stays 0.

Source files
------------

// File: rtl/alu_uart_sequencer.sv
// Byte-serial front end for the alu: collects A, B and opcode from the UART receiver,
// captures the alu result and hands it to the transmitter. Optional macro: OP_CHECK_EN.
module alu_uart_sequencer #(
    parameter int unsigned N_BITS = 8,
    parameter int unsigned N_OP   = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N_BITS-1:0] i_rx_data,
    input  logic              i_rx_done,
    input  logic [N_BITS-1:0] i_alu_result,
    input  logic              i_tx_done,
    output logic [N_BITS-1:0] o_dato_A,
    output logic [N_BITS-1:0] o_dato_B,
    output logic [N_OP-1:0]   o_operacion,
    output logic [N_BITS-1:0] o_tx_data,
    output logic              o_tx_start,
    output logic              o_busy,
    output logic              o_error
);

    typedef enum logic [2:0] {
        StWaitA,
        StWaitB,
        StWaitOp,
        StExec,
        StWaitTx
    } state_e;

    state_e            state_q, state_d;
    logic [N_BITS-1:0] dato_a_q, dato_a_d;
    logic [N_BITS-1:0] dato_b_q, dato_b_d;
    logic [N_OP-1:0]   op_q, op_d;
    logic [N_BITS-1:0] tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              error_q, error_d;

    logic [N_OP-1:0]   rx_op;
    logic              op_ok;
    logic              rx_unused_bits;

    // Only the low N_OP bits of the opcode byte are meaningful.
    assign rx_op          = i_rx_data[N_OP-1:0];
    assign rx_unused_bits = ^i_rx_data[N_BITS-1:N_OP];

`ifdef OP_CHECK_EN
    always_comb begin
        op_ok = rx_op inside {N_OP'(8'h20), N_OP'(8'h22), N_OP'(8'h24), N_OP'(8'h25),
                              N_OP'(8'h26), N_OP'(8'h03), N_OP'(8'h02), N_OP'(8'h27)};
    end
`else
    assign op_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        dato_a_d   = dato_a_q;
        dato_b_d   = dato_b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        error_d    = error_q;

        unique case (state_q)
            StWaitA: begin
                if (i_rx_done) begin
                    dato_a_d = i_rx_data;
                    state_d  = StWaitB;
                end
            end
            StWaitB: begin
                if (i_rx_done) begin
                    dato_b_d = i_rx_data;
                    state_d  = StWaitOp;
                end
            end
            StWaitOp: begin
                if (i_rx_done) begin
                    if (op_ok) begin
                        op_d    = rx_op;
                        error_d = 1'b0;
                        state_d = StExec;
                    end else begin
                        error_d = 1'b1;
                        state_d = StWaitA;
                    end
                end
            end
            StExec: begin
                // alu inputs have been stable for a full cycle; capture its result.
                tx_data_d  = i_alu_result;
                tx_start_d = 1'b1;
                state_d    = StWaitTx;
            end
            StWaitTx: begin
                if (i_tx_done) begin
                    state_d = StWaitA;
                end
            end
            default: state_d = StWaitA;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= StWaitA;
            dato_a_q   <= '0;
            dato_b_q   <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dato_a_q   <= dato_a_d;
            dato_b_q   <= dato_b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            error_q    <= error_d;
        end
    end

    assign o_dato_A    = dato_a_q;
    assign o_dato_B    = dato_b_q;
    assign o_operacion = op_q;
    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = tx_start_q;
    assign o_busy      = (state_q == StExec) || (state_q == StWaitTx);
    assign o_error     = error_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Self-checking bench for alu_uart_sequencer: directed cases plus randomized transactions
// scored against a transaction-level model. Honours OP_CHECK_EN like the design.
module tb_alu_uart_sequencer;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic [7:0] i_alu_result;
    logic       i_tx_done;
    logic [7:0] o_dato_A;
    logic [7:0] o_dato_B;
    logic [5:0] o_operacion;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_error;

    int n_pass  = 0;
    int n_total = 0;

    // Transaction-level model of what the outputs should hold.
    logic [7:0] exp_a, exp_b, exp_tx;
    logic [5:0] exp_op;
    logic       exp_err;

    logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27};

    alu_uart_sequencer #(
        .N_BITS(8),
        .N_OP  (6)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .i_alu_result(i_alu_result),
        .i_tx_done   (i_tx_done),
        .o_dato_A    (o_dato_A),
        .o_dato_B    (o_dato_B),
        .o_operacion (o_operacion),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_busy      (o_busy),
        .o_error     (o_error)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h03:   return 8'($signed(a) >>> b);
            6'h02:   return a >> b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    // Stand-in for the external combinational alu.
    assign i_alu_result = alu_ref(o_dato_A, o_dato_B, o_operacion);

    function automatic bit op_accepted(input logic [5:0] op);
`ifdef OP_CHECK_EN
        foreach (valid_ops[i]) if (valid_ops[i] == op) return 1'b1;
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clk);
        i_rx_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_A"}, 32'(o_dato_A), 32'h0);
        check_eq({tag, "_B"}, 32'(o_dato_B), 32'h0);
        check_eq({tag, "_op"}, 32'(o_operacion), 32'h0);
        check_eq({tag, "_txd"}, 32'(o_tx_data), 32'h0);
        check_eq({tag, "_start"}, 32'(o_tx_start), 32'h0);
        check_eq({tag, "_busy"}, 32'(o_busy), 32'h0);
        check_eq({tag, "_err"}, 32'(o_error), 32'h0);
    endtask

    // inj: 0 none, 1 byte 0x11 during WAIT_TX, 2 byte coincident with tx_done, 3 byte in EXEC.
    task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input int inj);
        logic [5:0] op;
        op = opb[5:0];
        send_byte(a);
        send_byte(b);
        exp_a = a;
        exp_b = b;
        send_byte(opb);
        if (op_accepted(op)) begin
            exp_op  = op;
            exp_tx  = alu_ref(a, b, op);
            exp_err = 1'b0;
            check_eq("exec_busy", 32'(o_busy), 32'h1);
            check_eq("exec_nostart", 32'(o_tx_start), 32'h0);
            if (inj == 3) begin
                i_rx_data = 8'h33;
                i_rx_done = 1'b1;
            end
            @(negedge i_clk);
            i_rx_done = 1'b0;
            check_eq("tx_start", 32'(o_tx_start), 32'h1);
            check_eq("tx_data", 32'(o_tx_data), 32'(exp_tx));
            check_eq("dato_A", 32'(o_dato_A), 32'(exp_a));
            check_eq("dato_B", 32'(o_dato_B), 32'(exp_b));
            check_eq("operacion", 32'(o_operacion), 32'(exp_op));
            check_eq("error", 32'(o_error), 32'(exp_err));
            @(negedge i_clk);
            check_eq("start_pulse_end", 32'(o_tx_start), 32'h0);
            check_eq("waittx_busy", 32'(o_busy), 32'h1);
            if (inj == 1) begin
                i_rx_data = 8'h11;
                i_rx_done = 1'b1;
                @(negedge i_clk);
                i_rx_done = 1'b0;
                check_eq("drop_busy", 32'(o_busy), 32'h1);
            end
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
            i_tx_done = 1'b1;
            if (inj == 2) begin
                i_rx_data = 8'h66;
                i_rx_done = 1'b1;
            end
            @(negedge i_clk);
            i_tx_done = 1'b0;
            i_rx_done = 1'b0;
            check_eq("done_idle", 32'(o_busy), 32'h0);
            check_eq("txd_hold", 32'(o_tx_data), 32'(exp_tx));
            check_eq("A_hold", 32'(o_dato_A), 32'(exp_a));
        end else begin
            exp_err = 1'b1;
            check_eq("bad_err", 32'(o_error), 32'h1);
            check_eq("bad_busy", 32'(o_busy), 32'h0);
            check_eq("bad_op_hold", 32'(o_operacion), 32'(exp_op));
            check_eq("bad_txd_hold", 32'(o_tx_data), 32'(exp_tx));
            repeat (3) begin
                @(negedge i_clk);
                check_eq("bad_nostart", 32'(o_tx_start), 32'h0);
            end
        end
    endtask

    initial begin
        logic [7:0] ra, rb, rop;
        i_reset   = 1'b1;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        exp_a = '0; exp_b = '0; exp_op = '0; exp_tx = '0; exp_err = 1'b0;
        repeat (3) @(negedge i_clk);
        check_all_zero("rst");
        i_reset = 1'b0;

        // tx_done while idle must be ignored.
        @(negedge i_clk);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        check_eq("txdone_idle_busy", 32'(o_busy), 32'h0);

        do_txn(8'h05, 8'h03, 8'h20, 0);
        do_txn(8'h03, 8'h05, 8'h22, 0);
        do_txn(8'h80, 8'h02, 8'h03, 0);
        do_txn(8'h0F, 8'hF0, 8'h27, 0);
        do_txn(8'h09, 8'h04, 8'h26, 1);
        do_txn(8'h01, 8'h01, 8'h24, 0);
        do_txn(8'h40, 8'h03, 8'h02, 2);
        do_txn(8'h0A, 8'h0B, 8'h25, 3);

        // Asynchronous reset after operand A has been captured.
        send_byte(8'h7F);
        #2 i_reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        exp_a = '0; exp_b = '0; exp_op = '0; exp_tx = '0; exp_err = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b0;
        do_txn(8'h02, 8'h04, 8'h25, 0);

        do_txn(8'h10, 8'h22, 8'hE0, 0);
        do_txn(8'h05, 8'h03, 8'h3F, 0);
        do_txn(8'h01, 8'h02, 8'h20, 0);

        for (int k = 0; k < 40; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                rop = {2'($urandom), valid_ops[$urandom_range(0, 7)]};
            end else begin
                rop = 8'($urandom);
            end
            do_txn(ra, rb, rop, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
